// File: rtl/act_pkg.sv
// Shared types and constants for the activation-accumulator sequencer.
package act_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StCapture,
    StOut
  } act_state_e;

  localparam int unsigned DBL_SIGN_BIT = 63;

  localparam logic [31:0] J_RUN  = 32'd0;
  localparam logic [31:0] J_HOLD = 32'd1;

  // 15 weight terms plus the bias term.
  localparam int unsigned MAC_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/act_sequencer_if.sv
// Result stream from the sequencer to the hidden-layer buffer (valid/ready).
interface act_sequencer_if;

  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [31:0] res_neuron;
  logic [31:0] res_sample;

  modport master (
    output res_valid,
    output res_data,
    output res_neuron,
    output res_sample,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_neuron,
    input  res_sample,
    output res_ready
  );

endinterface

// File: rtl/relu_dbl.sv
// Sign-bit ReLU on an IEEE-754 double; only built when ACT_RELU_EN is defined.
`ifdef ACT_RELU_EN
module relu_dbl
  import act_pkg::*;
(
  input  logic [63:0] din,
  output logic [63:0] dout
);

  // -0.0 also maps to +0.0; NaN with a clear sign passes unchanged.
  assign dout = din[DBL_SIGN_BIT] ? 64'h0 : din;

endmodule
`endif

// File: rtl/act_sequencer.sv
// Walks sample/neuron indices for the activation accumulator and streams its results.
// Optional ACT_RELU_EN: clamp negative results (sign bit set) to 64'h0.
module act_sequencer
  import act_pkg::*;
#(
  parameter int unsigned N_NEURONS  = 8,
  parameter int unsigned N_SAMPLES  = 4,
  parameter int unsigned MAC_CYCLES = MAC_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [31:0]      i,
  output logic [31:0]      j,
  output logic [31:0]      n_n1,
  input  logic [63:0]      act_out,
  input  logic             done_act_1,
  act_sequencer_if.master  res,
  output logic             busy,
  output logic             run_done,
  output logic             err
);

  act_state_e  state;
  logic [31:0] mac_cnt;
  logic [63:0] act_filt;
  logic        last_neuron;
  logic        last_sample;

`ifdef ACT_RELU_EN
  relu_dbl u_relu (
    .din  (act_out),
    .dout (act_filt)
  );
`else
  assign act_filt = act_out;
`endif

  assign last_neuron = (n_n1 == N_NEURONS - 1);
  assign last_sample = (i == N_SAMPLES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= StIdle;
      i              <= '0;
      n_n1           <= '0;
      j              <= J_HOLD;
      mac_cnt        <= '0;
      res.res_valid  <= 1'b0;
      res.res_data   <= '0;
      res.res_neuron <= '0;
      res.res_sample <= '0;
      busy           <= 1'b0;
      run_done       <= 1'b0;
      err            <= 1'b0;
    end else begin
      run_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state   <= StRun;
            i       <= '0;
            n_n1    <= '0;
            mac_cnt <= '0;
            j       <= J_RUN;
            busy    <= 1'b1;
          end
        end
        StRun: begin
          if (mac_cnt == MAC_CYCLES - 1) begin
            j       <= J_HOLD;
            mac_cnt <= '0;
            state   <= StCapture;
          end else begin
            mac_cnt <= mac_cnt + 32'd1;
          end
        end
        StCapture: begin
          // A missing done pulse is flagged but the value is still forwarded.
          res.res_data   <= act_filt;
          res.res_valid  <= 1'b1;
          res.res_neuron <= n_n1;
          res.res_sample <= i;
          if (!done_act_1) err <= 1'b1;
          state <= StOut;
        end
        StOut: begin
          if (res.res_valid && res.res_ready) begin
            res.res_valid <= 1'b0;
            if (!last_neuron) begin
              n_n1  <= n_n1 + 32'd1;
              j     <= J_RUN;
              state <= StRun;
            end else if (!last_sample) begin
              n_n1  <= '0;
              i     <= i + 32'd1;
              j     <= J_RUN;
              state <= StRun;
            end else begin
              // Indices stay put so they only ever move on a hold-to-run edge.
              run_done <= 1'b1;
              busy     <= 1'b0;
              state    <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
